cpu_step_ctrl: RTL

//  Consumes the slow divided clock from the clock divider and issues one-cycle CPU clock enables in the clk_in domain.

---
 rtl/cpu_step_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: turns divider ticks into one-cycle CPU enables in clk_in.
// Modes: free-run, debounced single-step, CPU-requested halt.
//
// Ports:
//   clk_in      system clock
//   rst         async active-low reset
//   tick_in     divided clock, async to clk_in
//   mode_run    1 = free-run, 0 = step mode
//   step_btn    raw, bouncing step button (async)
//   halt_req    CPU halt level (sync)
//   cpu_en      one-cycle CPU advance enable
//   cycle_count cpu_en pulses since reset (wraps)
//   state       0 IDLE, 1 RUN, 2 STEP_ARMED, 3 HALTED
//   halted      1 while state is HALTED
module cpu_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int CNT_W           = 32
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             tick_in,
  input  logic             mode_run,
  input  logic             step_btn,
  input  logic             halt_req,
  output logic             cpu_en,
  output logic [CNT_W-1:0] cycle_count,
  output logic [1:0]       state,
  output logic             halted
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 2)
                      ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST =
    DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    RUN        = 2'd1,
    STEP_ARMED = 2'd2,
    HALTED     = 2'd3
  } st_e;

  // tick_in synchroniser plus edge-detect flop
  logic t1, t2, t3;
  logic tick_rise;

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      t1 <= 1'b0;
      t2 <= 1'b0;
      t3 <= 1'b0;
    end else begin
      t1 <= tick_in;
      t2 <= t1;
      t3 <= t2;
    end
  end

  assign tick_rise = t2 & ~t3;

  // step_btn synchroniser and debouncer
  logic            b1, b2;
  logic            deb_q;
  logic [DB_W-1:0] db_cnt;
  logic            press_q;
  logic            db_take;

  // level has disagreed long enough to be accepted
  assign db_take = (b2 != deb_q) && (db_cnt == DB_LAST);

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      b1      <= 1'b0;
      b2      <= 1'b0;
      deb_q   <= 1'b0;
      db_cnt  <= '0;
      press_q <= 1'b0;
    end else begin
      b1      <= step_btn;
      b2      <= b1;
      press_q <= db_take & b2;
      if (b2 == deb_q) begin
        db_cnt <= '0;
      end else if (db_take) begin
        deb_q  <= b2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  // control FSM
  st_e             st_q, st_d;
  logic            en_d;
  logic            en_q;
  logic            halted_q;
  logic [CNT_W-1:0] cnt_q;

  always_comb begin
    st_d = st_q;
    en_d = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (halt_req)     st_d = HALTED;
        else if (mode_run) st_d = RUN;
        else if (press_q)  st_d = STEP_ARMED;
      end
      RUN: begin
        if (halt_req) begin
          st_d = HALTED;
        end else if (!mode_run) begin
          st_d = IDLE;
        end else if (tick_rise) begin
          en_d = 1'b1;
        end
      end
      STEP_ARMED: begin
        if (halt_req) begin
          st_d = HALTED;
        end else if (tick_rise) begin
          en_d = 1'b1;
          st_d = IDLE;
        end
      end
      HALTED: begin
        if (!halt_req && !mode_run) st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      st_q     <= IDLE;
      en_q     <= 1'b0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      st_q     <= st_d;
      en_q     <= en_d;
      halted_q <= (st_d == HALTED);
      if (en_d) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cpu_en      = en_q;
  assign cycle_count = cnt_q;
  assign state       = st_q;
  assign halted      = halted_q;

endmodule
